// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution controller.
// Feature macro used by the slice: CONV_CTRL_RELU_EN.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    MAC,
    DRAIN,
    OUT,
    DONE
  } state_t;

  function automatic int k_bits(input int maxk);
    return $clog2(maxk + 1);
  endfunction

  function automatic int x_addr_bits(input int rows, input int cols);
    return $clog2(rows * cols);
  endfunction

  function automatic int w_addr_bits(input int maxk);
    return $clog2(maxk * maxk);
  endfunction

  function automatic int x_addr(
    input int r,
    input int i,
    input int c,
    input int j,
    input int cols
  );
    return (r + i) * cols + (c + j);
  endfunction

endpackage

// File: rtl/conv_controller_if.sv
// AXI-Stream result channel of the convolution controller.
// Feature macro used by the slice: CONV_CTRL_RELU_EN.
interface conv_controller_if #(
  parameter int OUTW = 52
);
  logic signed [OUTW-1:0] TDATA;
  logic                   TVALID;
  logic                   TREADY;

  modport master (
    output TDATA,
    output TVALID,
    input  TREADY
  );

  modport slave (
    input  TDATA,
    input  TVALID,
    output TREADY
  );
endinterface

// File: rtl/conv_mac.sv
// Registered signed multiply-accumulate for one window.
// Feature macro used by the slice: CONV_CTRL_RELU_EN.
module conv_mac #(
  parameter int INW  = 24,
  parameter int OUTW = 52
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   en,
  input  logic signed [INW-1:0]  b,
  input  logic signed [INW-1:0]  x,
  input  logic signed [INW-1:0]  w,
  output logic signed [OUTW-1:0] acc,
  output logic signed [OUTW-1:0] acc_nxt
);

  logic signed [2*INW-1:0] prod;

  assign prod    = x * w;
  assign acc_nxt = acc + OUTW'(prod);

  // Bias preload, then wrap-around accumulation of products.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (load) begin
      acc <= OUTW'(b);
    end else if (en) begin
      acc <= acc_nxt;
    end
  end

endmodule

// File: rtl/conv_controller.sv
// Valid-region 2D convolution sequencer streaming results on AXI-Stream.
// Feature macro: CONV_CTRL_RELU_EN clamps negative results to zero.
module conv_controller
  import conv_pkg::*;
#(
  parameter int  INW         = 24,
  parameter int  OUTW        = 52,
  parameter int  R           = 9,
  parameter int  C           = 8,
  parameter int  MAXK        = 4,
  localparam int K_BITS      = k_bits(MAXK),
  localparam int X_ADDR_BITS = x_addr_bits(R, C),
  localparam int W_ADDR_BITS = w_addr_bits(MAXK)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inputs_loaded,
  input  logic [K_BITS-1:0]      K,
  input  logic signed [INW-1:0]  B,
  output logic [X_ADDR_BITS-1:0] X_read_addr,
  input  logic signed [INW-1:0]  X_data,
  output logic [W_ADDR_BITS-1:0] W_read_addr,
  input  logic signed [INW-1:0]  W_data,
  output logic                   compute_finished,
  conv_controller_if.master      m_axis
);

  localparam int RB = $clog2(R);
  localparam int CB = $clog2(C);

  state_t state;
  state_t state_nxt;

  logic [K_BITS-1:0]      kq;
  logic signed [INW-1:0]  bq;
  logic [RB-1:0]          r;
  logic [CB-1:0]          c;
  logic [K_BITS-1:0]      i;
  logic [K_BITS-1:0]      j;
  logic                   issue_q;
  logic                   tvalid_q;
  logic signed [OUTW-1:0] tdata_q;
  logic signed [OUTW-1:0] acc;
  logic signed [OUTW-1:0] acc_nxt;
  logic signed [OUTW-1:0] result;
  logic signed [INW-1:0]  mac_b;
  logic                   mac_load;
  logic                   mac_en;
  logic                   k_ok;
  logic                   last_ij;
  logic                   last_win;
  logic                   hs;

  assign k_ok = int'(K) >= 2 && int'(K) <= MAXK &&
                int'(K) <= R && int'(K) <= C;

  assign last_ij = int'(i) == int'(kq) - 1 &&
                   int'(j) == int'(kq) - 1;

  assign last_win = int'(r) == R - int'(kq) &&
                    int'(c) == C - int'(kq);

  assign hs = tvalid_q && m_axis.TREADY;

  assign m_axis.TDATA  = tdata_q;
  assign m_axis.TVALID = tvalid_q;

  // Bias comes straight from the port in START, from the latch afterwards.
  assign mac_b = (state == START) ? B : bq;

  conv_mac #(
    .INW  (INW),
    .OUTW (OUTW)
  ) u_mac (
    .clk     (clk),
    .reset   (reset),
    .load    (mac_load),
    .en      (mac_en),
    .b       (mac_b),
    .x       (X_data),
    .w       (W_data),
    .acc     (acc),
    .acc_nxt (acc_nxt)
  );

  // Final window value, optionally clamped at zero.
  always_comb begin
`ifdef CONV_CTRL_RELU_EN
    result = acc_nxt[OUTW-1] ? '0 : acc_nxt;
`else
    result = acc_nxt;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (inputs_loaded) state_nxt = START;
      START: state_nxt = k_ok ? MAC : DONE;
      MAC:   if (last_ij) state_nxt = DRAIN;
      DRAIN: state_nxt = OUT;
      OUT:   if (hs) state_nxt = last_win ? DONE : MAC;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address issue, accumulator control and completion pulse.
  always_comb begin
    X_read_addr      = '0;
    W_read_addr      = '0;
    compute_finished = 1'b0;
    mac_load         = 1'b0;
    mac_en           = issue_q;
    unique case (1'b1)
      state == MAC: begin
        X_read_addr = X_ADDR_BITS'(x_addr(int'(r), int'(i),
                                          int'(c), int'(j), C));
        W_read_addr = W_ADDR_BITS'(int'(i) * int'(kq) + int'(j));
      end
      state == START: mac_load = k_ok;
      state == OUT:   mac_load = hs && !last_win;
      state == DONE:  compute_finished = 1'b1;
      default: ;
    endcase
  end

  // Window/tap counters, run constants and output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kq       <= '0;
      bq       <= '0;
      r        <= '0;
      c        <= '0;
      i        <= '0;
      j        <= '0;
      issue_q  <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
    end else begin
      issue_q <= (state == MAC);
      unique case (state)
        START: begin
          kq <= K;
          bq <= B;
          r  <= '0;
          c  <= '0;
          i  <= '0;
          j  <= '0;
        end
        MAC: begin
          if (last_ij) begin
            i <= '0;
            j <= '0;
          end else if (int'(j) == int'(kq) - 1) begin
            j <= '0;
            i <= i + K_BITS'(1);
          end else begin
            j <= j + K_BITS'(1);
          end
        end
        DRAIN: begin
          tdata_q  <= result;
          tvalid_q <= 1'b1;
        end
        OUT: begin
          if (hs) begin
            tvalid_q <= 1'b0;
            if (!last_win) begin
              if (int'(c) == C - int'(kq)) begin
                c <= '0;
                r <= r + RB'(1);
              end else begin
                c <= c + CB'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_controller.sv
// Directed bench for conv_controller with a window-sum reference model.
// Honours CONV_CTRL_RELU_EN in the reference model.
module tb_conv_controller;
  import conv_pkg::*;

  localparam int INW  = 24;
  localparam int OUTW = 52;
  localparam int R    = 9;
  localparam int C    = 8;
  localparam int MAXK = 4;
  localparam int KB   = k_bits(MAXK);
  localparam int XB   = x_addr_bits(R, C);
  localparam int WB   = w_addr_bits(MAXK);
  localparam int LIM  = 5000;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  inputs_loaded = 1'b0;
  logic [KB-1:0]         K = '0;
  logic signed [INW-1:0] B = '0;
  logic signed [INW-1:0] X_data;
  logic signed [INW-1:0] W_data;
  logic [XB-1:0]         X_read_addr;
  logic [WB-1:0]         W_read_addr;
  logic                  compute_finished;

  conv_controller_if #(.OUTW(OUTW)) axis ();

  conv_controller #(
    .INW  (INW),
    .OUTW (OUTW),
    .R    (R),
    .C    (C),
    .MAXK (MAXK)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .inputs_loaded    (inputs_loaded),
    .K                (K),
    .B                (B),
    .X_read_addr      (X_read_addr),
    .X_data           (X_data),
    .W_read_addr      (W_read_addr),
    .W_data           (W_data),
    .compute_finished (compute_finished),
    .m_axis           (axis)
  );

  always #5 clk = ~clk;

  logic signed [INW-1:0] xm [R*C];
  logic signed [INW-1:0] wm [MAXK*MAXK];

  always @(posedge clk) begin
    X_data <= xm[X_read_addr];
    W_data <= wm[W_read_addr];
  end

  int     n_checks = 0;
  int     n_fail   = 0;
  int     n_out    = 0;
  int     n_fin    = 0;
  int     rmode    = 0;
  longint exp_q[$];
  longint got0;
  longint got1;
  bit     prev_stall = 1'b0;
  bit     tv_seen = 1'b0;
  logic signed [OUTW-1:0] prev_data;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected stream: bias plus window dot product, wrapped to OUTW.
  function automatic void build(input int k, input int b);
    exp_q.delete();
    if (k < 2 || k > MAXK || k > R || k > C) return;
    for (int rr = 0; rr <= R - k; rr++) begin
      for (int cc = 0; cc <= C - k; cc++) begin
        longint s;
        logic signed [OUTW-1:0] v;
        s = b;
        for (int ii = 0; ii < k; ii++)
          for (int jj = 0; jj < k; jj++)
            s += longint'(xm[(rr + ii) * C + cc + jj]) *
                 longint'(wm[ii * k + jj]);
        v = s[OUTW-1:0];
`ifdef CONV_CTRL_RELU_EN
        if (v < 0) v = '0;
`endif
        exp_q.push_back(longint'(v));
      end
    end
  endfunction

  always @(posedge clk) begin
    #1;
    if (rmode == 1) axis.TREADY = ~axis.TREADY;
    else axis.TREADY = 1'b1;
  end

  // Per-cycle compare against the reference stream.
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_tvalid", longint'(axis.TVALID), 1);
        chk("hold_tdata", longint'(axis.TDATA), longint'(prev_data));
      end
      if (axis.TVALID) tv_seen = 1'b1;
      if (axis.TVALID && axis.TREADY) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_output: got %0d expected none",
                   longint'(axis.TDATA));
        end else begin
          chk("tdata", longint'(axis.TDATA), exp_q.pop_front());
        end
        if (n_out == 0) got0 = longint'(axis.TDATA);
        if (n_out == 1) got1 = longint'(axis.TDATA);
        n_out++;
      end
      if (compute_finished) begin
        n_fin++;
        chk("queue_empty_at_finish", longint'(exp_q.size()), 0);
      end
      prev_stall = axis.TVALID && !axis.TREADY;
      prev_data  = axis.TDATA;
    end
  end

  task automatic run(input int k, input int b, input int mode,
                     input int abort_at, output int ncyc);
    int cyc;
    build(k, b);
    n_out   = 0;
    n_fin   = 0;
    tv_seen = 1'b0;
    rmode   = mode;
    K       = KB'(k);
    B       = INW'(b);
    @(posedge clk);
    #1 inputs_loaded = 1'b1;
    cyc = 0;
    while (n_fin == 0 && cyc < LIM) begin
      @(posedge clk);
      #1;
      cyc++;
      if (abort_at > 0 && n_out >= abort_at) begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_tvalid", longint'(axis.TVALID), 0);
        chk("abort_tdata", longint'(axis.TDATA), 0);
        chk("abort_xaddr", longint'(X_read_addr), 0);
        chk("abort_waddr", longint'(W_read_addr), 0);
        chk("abort_finished", longint'(compute_finished), 0);
        inputs_loaded = 1'b0;
        exp_q.delete();
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_finish", longint'(n_fin), 0);
        ncyc = cyc;
        return;
      end
    end
    inputs_loaded = 1'b0;
    ncyc = cyc;
    if (cyc >= LIM) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: got %0d cycles required < %0d", cyc, LIM);
    end
    rmode = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("finish_pulses", longint'(n_fin), 1);
    chk("outputs_left", longint'(exp_q.size()), 0);
  endtask

  task automatic fill_x(input int mode);
    for (int n = 0; n < R * C; n++) begin
      unique case (mode)
        0: xm[n] = INW'(0);
        1: xm[n] = INW'(1);
        2: xm[n] = INW'(n);
        default: xm[n] = (n % 2 == 1) ? INW'(24'h7FFFFF)
                                      : INW'(24'h800000);
      endcase
    end
  endtask

  task automatic fill_w(input int mode, input int k);
    for (int n = 0; n < MAXK * MAXK; n++) wm[n] = INW'(0);
    for (int n = 0; n < k * k; n++) begin
      unique case (mode)
        0: wm[n] = INW'(1);
        1: wm[n] = (n == 0 || n == 3) ? INW'(1) : INW'(0);
        2: wm[n] = INW'(7);
        default: wm[n] = (n % 3 == 0) ? INW'(24'h800000)
                                      : INW'(24'h7FFFFF);
      endcase
    end
  endtask

  initial begin
    int nc;
    axis.TREADY = 1'b1;
    fill_x(0);
    fill_w(0, MAXK);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", longint'(axis.TVALID), 0);
    chk("rst_tdata", longint'(axis.TDATA), 0);
    chk("rst_xaddr", longint'(X_read_addr), 0);
    chk("rst_waddr", longint'(W_read_addr), 0);
    chk("rst_finished", longint'(compute_finished), 0);
    reset = 1'b1;

    fill_x(1);
    fill_w(0, 3);
    run(3, 0, 0, 0, nc);
    chk("c1_count", longint'(n_out), 42);
    chk("c1_first", got0, 9);
    chk("c1_cycles", longint'(nc), 2 + 42 * 11 + 1);

    fill_x(2);
    fill_w(1, 2);
    run(2, 5, 0, 0, nc);
    chk("c2_count", longint'(n_out), 56);
    chk("c2_first", got0, 14);
    chk("c2_second", got1, 16);

    fill_x(0);
    fill_w(2, 4);
    run(4, -100, 0, 0, nc);
    chk("c3_count", longint'(n_out), 30);
`ifdef CONV_CTRL_RELU_EN
    chk("c3_first", got0, 0);
`else
    chk("c3_first", got0, -100);
`endif

    fill_x(1);
    fill_w(0, 3);
    run(3, 0, 1, 0, nc);
    chk("c4_count", longint'(n_out), 42);
    chk("c4_first", got0, 9);

    run(1, 0, 0, 0, nc);
    chk("c5_no_tvalid", longint'(tv_seen), 0);
    chk("c5_latency_ok", longint'(nc >= 2 && nc <= 4), 1);

    run(5, 0, 0, 0, nc);
    chk("k5_no_tvalid", longint'(tv_seen), 0);

    run(3, 0, 0, 9, nc);
    run(3, 0, 0, 0, nc);
    chk("c6_rerun_count", longint'(n_out), 42);
    chk("c6_rerun_first", got0, 9);

    fill_x(3);
    fill_w(3, 4);
    run(4, -1234, 1, 0, nc);
    chk("ext_count", longint'(n_out), 30);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
